// File: rtl/mips_ex_bjp_resolve_pkg.sv
// Shared types for EX-stage branch/jump resolution: widths, FSM states, target select.
// Combinational helpers only, no latency or flow-control implications.
package mips_ex_bjp_resolve_pkg;

  localparam int MIPS_ADDR_WIDTH = 32;
  localparam int MIPS_DATA_WIDTH = 32;
  localparam int JIDX_WIDTH      = 26;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } bjp_state_t;

  typedef enum logic [1:0] {
    TGT_COND = 2'd0,
    TGT_JUMP = 2'd1,
    TGT_JR   = 2'd2
  } tgt_sel_t;

  // Pseudo-direct j/jal target: keep the top nibble of PC+4.
  function automatic logic [MIPS_ADDR_WIDTH-1:0] jump_target(
    input logic [MIPS_ADDR_WIDTH-1:0] pc_incr,
    input logic [JIDX_WIDTH-1:0]      jidx
  );
    return {pc_incr[MIPS_ADDR_WIDTH-1 -: 4], jidx, 2'b00};
  endfunction

endpackage

// File: rtl/mips_ex_bjp_resolve_if.sv
// EX-side branch operands plus the IF redirect valid/ready channel.
// The slave modport is the resolve stage; the master is the surrounding pipeline.
interface mips_ex_bjp_resolve_if;
  import mips_ex_bjp_resolve_pkg::*;

  logic                       ex_valid;
  logic                       ex_cond;
  logic                       ex_jump;
  logic                       ex_jr;
  logic                       alu_cmp_res;
  logic [MIPS_ADDR_WIDTH-1:0] bjp_pc_incr;
  logic [MIPS_DATA_WIDTH-1:0] bjp_imm;
  logic [MIPS_DATA_WIDTH-1:0] bjp_rs;
  logic [JIDX_WIDTH-1:0]      bjp_jidx;
  logic                       kill;
  logic                       redir_valid;
  logic                       redir_ready;
  logic [MIPS_ADDR_WIDTH-1:0] redir_pc;
  logic                       flush_younger;
  logic                       ex_stall;
  logic                       err_misalign;

  modport master (
    output ex_valid, ex_cond, ex_jump, ex_jr, alu_cmp_res,
           bjp_pc_incr, bjp_imm, bjp_rs, bjp_jidx, kill, redir_ready,
    input  redir_valid, redir_pc, flush_younger, ex_stall, err_misalign
  );

  modport slave (
    input  ex_valid, ex_cond, ex_jump, ex_jr, alu_cmp_res,
           bjp_pc_incr, bjp_imm, bjp_rs, bjp_jidx, kill, redir_ready,
    output redir_valid, redir_pc, flush_younger, ex_stall, err_misalign
  );

endinterface

// File: rtl/mips_ex_bjp_resolve_sat_counter.sv
// Saturating event counter; count visible one cycle after inc, clr has priority.
// No backpressure: holds at all-ones instead of wrapping.
module mips_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/mips_ex_bjp_resolve.sv
// Resolves EX branches/jumps (predict-not-taken) and raises a registered IF redirect one cycle later.
// Redirect is held with flush/stall until IF accepts it or a kill drops it.
module mips_ex_bjp_resolve
  import mips_ex_bjp_resolve_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_ex_bjp_resolve_if.slave bjp,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] bjp_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  bjp_state_t                 state_q;
  bjp_state_t                 state_d;
  tgt_sel_t                   tgt_sel;
  logic [MIPS_ADDR_WIDTH-1:0] target;
  logic [MIPS_ADDR_WIDTH-1:0] redir_pc_q;
  logic                       err_q;
  logic                       is_bjp;
  logic                       accept;
  logic                       taken;
  logic                       misalign;
  logic                       redir_go;

  // Wrong-path instructions arriving while a redirect is pending are never accepted.
  always_comb begin
    is_bjp   = bjp.ex_cond | bjp.ex_jump | bjp.ex_jr;
    accept   = bjp.ex_valid & is_bjp & (state_q == IDLE) & ~bjp.kill;
    taken    = bjp.ex_jump | bjp.ex_jr | (bjp.ex_cond & bjp.alu_cmp_res);
    misalign = bjp.ex_jr & (bjp.bjp_rs[1:0] != 2'b00);
    redir_go = accept & taken & ~misalign;
  end

  always_comb begin
    tgt_sel = TGT_COND;
    if (bjp.ex_jr) begin
      tgt_sel = TGT_JR;
    end else if (bjp.ex_jump) begin
      tgt_sel = TGT_JUMP;
    end
  end

  always_comb begin
    target = '0;
    case (tgt_sel)
      TGT_COND: target = bjp.bjp_pc_incr + (bjp.bjp_imm[MIPS_ADDR_WIDTH-1:0] << 2);
      TGT_JUMP: target = jump_target(bjp.bjp_pc_incr, bjp.bjp_jidx);
      TGT_JR:   target = bjp.bjp_rs[MIPS_ADDR_WIDTH-1:0];
      default:  target = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    bjp.redir_valid   = 1'b0;
    bjp.flush_younger = 1'b0;
    bjp.ex_stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redir_go) begin
          state_d = REDIR;
        end
      end
      REDIR: begin
        bjp.redir_valid   = 1'b1;
        bjp.flush_younger = 1'b1;
        bjp.ex_stall      = 1'b1;
        if (bjp.kill || bjp.redir_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Target only loads on a new redirect, so it is stable for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= accept & misalign;
      if (redir_go) begin
        redir_pc_q <= target;
      end
    end
  end

  assign bjp.redir_pc     = redir_pc_q;
  assign bjp.err_misalign = err_q;

  mips_sat_counter #(.WIDTH(CNT_WIDTH)) u_bjp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (cnt_clr),
    .cnt   (bjp_cnt)
  );

  mips_sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept & taken),
    .clr   (cnt_clr),
    .cnt   (taken_cnt)
  );

  a_decode_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    bjp.ex_valid |-> $onehot0({bjp.ex_cond, bjp.ex_jump, bjp.ex_jr}));

endmodule

// File: tb/tb_mips_ex_bjp_resolve.sv
// Scoreboard bench for mips_ex_bjp_resolve: expected redirect targets are queued at issue
// and checked when IF accepts; counters and flags are checked against a small model.
module tb_mips_ex_bjp_resolve;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] bjp_cnt;
  logic [CW-1:0] taken_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_redir_q[$];
  int          exp_bjp = 0;
  int          exp_taken = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;

  always #5 clk = ~clk;

  mips_ex_bjp_resolve_if bjp ();

  mips_ex_bjp_resolve #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bjp       (bjp),
    .cnt_clr   (cnt_clr),
    .bjp_cnt   (bjp_cnt),
    .taken_cnt (taken_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic c, input logic j, input logic r, input logic cmp,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs, input logic [25:0] jidx);
    bjp.ex_valid    = 1'b1;
    bjp.ex_cond     = c;
    bjp.ex_jump     = j;
    bjp.ex_jr       = r;
    bjp.alu_cmp_res = cmp;
    bjp.bjp_pc_incr = pc;
    bjp.bjp_imm     = imm;
    bjp.bjp_rs      = rs;
    bjp.bjp_jidx    = jidx;
  endtask

  task automatic clear_ex();
    bjp.ex_valid = 1'b0;
    bjp.ex_cond  = 1'b0;
    bjp.ex_jump  = 1'b0;
    bjp.ex_jr    = 1'b0;
  endtask

  // Reference: outcome and target straight from the ISA definition.
  task automatic expect_br(input logic c, input logic j, input logic r, input logic cmp,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rs, input logic [25:0] jidx);
    logic        tk;
    logic [31:0] tgt;
    tk = j | r | (c & cmp);
    if (exp_bjp < CMAX) exp_bjp++;
    if (tk && exp_taken < CMAX) exp_taken++;
    if (r)      tgt = rs;
    else if (j) tgt = {pc[31:28], jidx, 2'b00};
    else        tgt = pc + {imm[29:0], 2'b00};
    if (tk && !(r && rs[1:0] != 2'b00)) exp_redir_q.push_back(tgt);
  endtask

  task automatic issue(input logic c, input logic j, input logic r, input logic cmp,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs, input logic [25:0] jidx);
    set_ex(c, j, r, cmp, pc, imm, rs, jidx);
    expect_br(c, j, r, cmp, pc, imm, rs, jidx);
    step();
    clear_ex();
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    exp_bjp = 0;
    exp_taken = 0;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_bjp_cnt"}, 64'(bjp_cnt), 64'(exp_bjp));
    chk({tag, "_taken_cnt"}, 64'(taken_cnt), 64'(exp_taken));
  endtask

  // Scoreboard side: pop on each IF acceptance, and watch request stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid && bjp.redir_valid) chk("redir_pc_hold", 64'(bjp.redir_pc), 64'(prev_pc));
      if (bjp.redir_valid && bjp.redir_ready && !bjp.kill) begin
        if (exp_redir_q.size() == 0) chk("redir_unexpected", 64'(bjp.redir_valid), 64'd0);
        else chk("redir_pc", 64'(bjp.redir_pc), 64'(exp_redir_q.pop_front()));
        prev_valid <= 1'b0;
      end else begin
        prev_valid <= bjp.redir_valid;
      end
      prev_pc <= bjp.redir_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ex();
    bjp.alu_cmp_res = 1'b0;
    bjp.bjp_pc_incr = '0;
    bjp.bjp_imm     = '0;
    bjp.bjp_rs      = '0;
    bjp.bjp_jidx    = '0;
    bjp.kill        = 1'b0;
    bjp.redir_ready = 1'b0;

    #12;
    chk("rst_valid", 64'(bjp.redir_valid), 64'd0);
    chk("rst_flush", 64'(bjp.flush_younger), 64'd0);
    chk("rst_stall", 64'(bjp.ex_stall), 64'd0);
    chk("rst_err", 64'(bjp.err_misalign), 64'd0);
    chk("rst_pc", 64'(bjp.redir_pc), 64'd0);
    chk_cnt("rst");
    rst_n = 1'b1;
    step();

    // beq taken, backward offset
    bjp.redir_ready = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'hFFFF_FFFC, '0, '0);
    @(negedge clk);
    chk("beq_valid", 64'(bjp.redir_valid), 64'd1);
    chk("beq_flush", 64'(bjp.flush_younger), 64'd1);
    chk("beq_stall", 64'(bjp.ex_stall), 64'd1);
    chk("beq_pc_lit", 64'(bjp.redir_pc), 64'h0000_0FF4);
    chk("beq_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'h11);
    step();
    @(negedge clk);
    chk("beq_valid_drop", 64'(bjp.redir_valid), 64'd0);
    chk("beq_flush_drop", 64'(bjp.flush_younger), 64'd0);

    // three back-to-back not-taken bne
    clr_cnt();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'h8, '0, '0);
      @(negedge clk);
      chk("bne_valid", 64'(bjp.redir_valid), 64'd0);
      chk("bne_flush", 64'(bjp.flush_younger), 64'd0);
      chk_cnt("bne");
    end
    chk("bne_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'h30);

    // j with IF stalled four cycles, wrong-path branch in the acceptance cycle
    step();
    bjp.redir_ready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0004, '0, '0, 26'h100);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        bjp.redir_ready = 1'b1;
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h4, '0, '0);
      end
      @(negedge clk);
      chk("j_valid", 64'(bjp.redir_valid), 64'd1);
      chk("j_stall", 64'(bjp.ex_stall), 64'd1);
      chk("j_flush", 64'(bjp.flush_younger), 64'd1);
      chk("j_pc_lit", 64'(bjp.redir_pc), 64'h8000_0400);
      step();
    end
    // turnaround: a branch right after the redirect is accepted
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h6000, 32'h4, '0, '0);
    expect_br(1'b1, 1'b0, 1'b0, 1'b0, 32'h6000, 32'h4, '0, '0);
    @(negedge clk);
    chk("j_valid_drop", 64'(bjp.redir_valid), 64'd0);
    chk("j_stall_drop", 64'(bjp.ex_stall), 64'd0);
    step();
    clear_ex();
    @(negedge clk);
    chk_cnt("turn");
    chk("turn_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'h51);

    // jr misaligned, then jr aligned
    clr_cnt();
    bjp.redir_ready = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h0040_0002, '0);
    @(negedge clk);
    chk("jrm_err", 64'(bjp.err_misalign), 64'd1);
    chk("jrm_valid", 64'(bjp.redir_valid), 64'd0);
    chk("jrm_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'h11);
    step();
    @(negedge clk);
    chk("jrm_err_drop", 64'(bjp.err_misalign), 64'd0);
    chk("jrm_valid2", 64'(bjp.redir_valid), 64'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h0040_0008, '0);
    @(negedge clk);
    chk("jr_valid", 64'(bjp.redir_valid), 64'd1);
    chk("jr_err", 64'(bjp.err_misalign), 64'd0);
    step();

    // kill while a redirect is pending with a wrong-path jump present
    bjp.redir_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h4, '0, '0);
    @(negedge clk);
    chk("kill_pre_valid", 64'(bjp.redir_valid), 64'd1);
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, '0, '0, 26'h5);
    step();
    @(negedge clk);
    chk("kill_hold_valid", 64'(bjp.redir_valid), 64'd1);
    chk_cnt("kill_wp");
    step();
    bjp.kill = 1'b1;
    void'(exp_redir_q.pop_front());
    step();
    bjp.kill = 1'b0;
    clear_ex();
    @(negedge clk);
    chk("kill_valid", 64'(bjp.redir_valid), 64'd0);
    chk("kill_flush", 64'(bjp.flush_younger), 64'd0);
    chk("kill_stall", 64'(bjp.ex_stall), 64'd0);
    chk_cnt("kill");
    // kill in IDLE suppresses acceptance
    bjp.kill = 1'b1;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000, 32'h4, '0, '0);
    step();
    bjp.kill = 1'b0;
    clear_ex();
    @(negedge clk);
    chk("killidle_valid", 64'(bjp.redir_valid), 64'd0);
    chk_cnt("killidle");

    // saturation at 15, then clear racing a branch
    step();
    clr_cnt();
    bjp.redir_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h700, 32'h1, '0, '0);
    end
    @(negedge clk);
    chk("sat_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'hF0);
    for (int i = 0; i < 17; i++) begin
      issue(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h0000_0801, '0);
    end
    @(negedge clk);
    chk("sat_taken_lit", 64'({bjp_cnt, taken_cnt}), 64'hFF);
    chk("sat_valid", 64'(bjp.redir_valid), 64'd0);
    chk_cnt("sat");
    cnt_clr = 1'b1;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h900, 32'h1, '0, '0);
    exp_bjp = 0;
    exp_taken = 0;
    step();
    cnt_clr = 1'b0;
    clear_ex();
    @(negedge clk);
    chk("clr_cnt_lit", 64'({bjp_cnt, taken_cnt}), 64'h00);

    // reset asserted mid-redirect
    step();
    bjp.redir_ready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0004, '0, '0, 26'h3);
    @(negedge clk);
    chk("rstmid_valid_pre", 64'(bjp.redir_valid), 64'd1);
    chk("rstmid_pc_pre", 64'(bjp.redir_pc), 64'h4000_000C);
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_redir_q.pop_front());
    exp_bjp = 0;
    exp_taken = 0;
    chk("rstmid_valid", 64'(bjp.redir_valid), 64'd0);
    chk("rstmid_pc", 64'(bjp.redir_pc), 64'd0);
    chk_cnt("rstmid");
    step();
    rst_n = 1'b1;
    bjp.redir_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rstrel_valid", 64'(bjp.redir_valid), 64'd0);
    chk("rstrel_flush", 64'(bjp.flush_younger), 64'd0);
    step();
    @(negedge clk);
    chk("rstrel_valid2", 64'(bjp.redir_valid), 64'd0);

    chk("redir_q_empty", 64'(exp_redir_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_ex_bjp_resolve.md
# mips_ex_bjp_resolve

Branch/jump resolution stage, directly downstream of the EX-stage branch operand/compare logic. It takes the shared-ALU compare result plus branch decode info and computes the taken/not-taken outcome and the target PC. On a taken outcome it issues a registered redirect request to IF, held until accepted, and flushes the younger wrong-path instructions. Static predict-not-taken, no delay slot; also keeps saturating branch statistics.

## Interface
- `CNT_WIDTH`, 32, width of statistics counters
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX holds a valid instruction
- `ex_cond`  in  1  conditional branch (beq/bne/bgez/bltz/blez/bgtz)
- `ex_jump`  in  1  j/jal
- `ex_jr`  in  1  jr/jalr
- `alu_cmp_res`  in  1  shared-ALU compare result for the selected condition
- `bjp_pc_incr`  in  `MIPS_ADDR_WIDTH`  PC+4 of EX instruction
- `bjp_imm`  in  `MIPS_DATA_WIDTH`  sign-extended 16-bit offset
- `bjp_rs`  in  `MIPS_DATA_WIDTH`  forwarded rs (jr target)
- `bjp_jidx`  in  26  jump index
- `kill`  in  1  exception flush from MEM/WB, highest priority
- `cnt_clr`  in  1  synchronous clear of counters
- `redir_valid`  out  1  redirect request to IF
- `redir_ready`  in  1  IF accepts redirect
- `redir_pc`  out  `MIPS_ADDR_WIDTH`  redirect target
- `flush_younger`  out  1  squash IF/ID and EX-input instruction
- `ex_stall`  out  1  hold IF/ID/EX while redirect pending
- `err_misalign`  out  1  one-cycle pulse, jr target [1:0]≠0
- `bjp_cnt`, `taken_cnt`  out  `CNT_WIDTH`  resolved-branch and taken-branch counts

## Operation
- Accept condition: `ex_valid & (ex_cond|ex_jump|ex_jr)` in state IDLE and `kill`=0.
- taken = `ex_jump | ex_jr | (ex_cond & alu_cmp_res)`; decode bits are one-hot, more than one set is illegal (assertion).
- Targets, all modulo 2^ADDR_WIDTH: cond = `bjp_pc_incr + (bjp_imm << 2)`; jump = {`bjp_pc_incr`[31:28], `bjp_jidx`, 2'b00}; jr = `bjp_rs`.
- jr with `bjp_rs`[1:0]≠0: no redirect, `err_misalign` pulses next cycle, counters still update (counted taken).
- FSM states IDLE, REDIR.
  - IDLE→REDIR on accepted taken branch; `redir_pc` registered.
  - REDIR→IDLE on `redir_valid & redir_ready`, or on `kill`.
- Not-taken branch: counters only, stays IDLE, no flush.
- In REDIR: `redir_valid`=1, `flush_younger`=1, `ex_stall`=1; `redir_pc` stable; `ex_*` inputs ignored (wrong path), including the acceptance cycle.
- `kill` in any state: return to IDLE, drop redirect, suppress acceptance that cycle; counters do not count the killed instruction.
- Counters: `bjp_cnt` +1 per accepted branch, `taken_cnt` +1 per taken; saturate at all-ones; `cnt_clr` wins over increment.

## Timing
- Reset (async, `rst_n`=0): IDLE; `redir_valid`, `flush_younger`, `ex_stall`, `err_misalign`=0; `redir_pc`=0; counters=0.
- Latency: branch accepted cycle N → `redir_valid` high from N+1; counters visible N+1.
- Handshake: `redir_valid` never drops nor `redir_pc` changes before acceptance (except `kill`/reset); handshake completes at the rising edge where both are high; outputs low the next cycle.
- Minimum turnaround: new branch acceptable in the cycle after REDIR→IDLE.
- Back-to-back not-taken branches: one per cycle, no bubbles.
- Reset released mid-REDIR: pending redirect lost, no spurious request.

## Structure
- Shared package/include: state encoding (IDLE/REDIR), target-select encoding, `MIPS_ADDR_WIDTH`/`MIPS_DATA_WIDTH` macros already shared.
- One sub-module natural: `mips_sat_counter` (parameterised width, inc, clr), instantiated twice.
- Target mux and taken logic combinational in top; FSM and `redir_pc` register in top.

## Test plan
- beq taken, `bjp_pc_incr`=0x0000_1004, `bjp_imm`=0xFFFF_FFFC, cmp=1, `redir_ready`=1 → N+1: `redir_valid`=1, `redir_pc`=0x0000_0FF4, flush 1 cycle; counts 1/1.
- bne not taken (cmp=0) ×3 consecutive → no redirect, no flush, `bjp_cnt`=3, `taken_cnt`=0.
- j, `bjp_pc_incr`=0x8000_0004, `bjp_jidx`=0x0000_100 → `redir_pc`=0x8000_0400; `redir_ready` low 4 cycles → valid/pc/stall/flush held 5 cycles, drop after acceptance.
- jr `bjp_rs`=0x0040_0002 → no redirect, `err_misalign` 1-cycle pulse at N+1, counts 1/1.
- REDIR pending with `ex_valid` branch present, then `kill` → return IDLE, `redir_valid` 0 next cycle, wrong-path branch not counted.
- Counters preset near max (CNT_WIDTH=4, 15 branches then 2 more) → hold at 15; `cnt_clr` with simultaneous branch → 0.
